// File: rtl/conditional_mux_scan.sv
// conditional_mux_scan: registered N_CH-way channel sampler.
// Direct mode samples one selected channel; scan mode sweeps the enabled
// channels in ascending order at up to one sample per clock.
//
// Ports:
//   clk        rising-edge clock for all state
//   rst_n      asynchronous active-low reset
//   i          packed channels, channel k at [k*W +: W]
//   s          direct-mode channel select (latched on start)
//   mode       0 = direct, 1 = scan (latched on start)
//   en_mask    scan-mode channel enables (latched on start)
//   start      single-cycle request, honoured only while idle
//   out        registered sample data
//   out_ch     channel index of the sample in out
//   out_valid  out/out_ch hold a sample not yet accepted
//   out_ready  consumer accept; transfer when out_valid & out_ready
//   busy       operation in progress
//   done       one-cycle pulse after the final transfer
module conditional_mux_scan #(
    parameter  int N_CH  = 8,
    parameter  int W     = 1,
    localparam int SEL_W = ($clog2(N_CH) > 1) ? $clog2(N_CH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_CH*W-1:0] i,
    input  logic [SEL_W-1:0]  s,
    input  logic              mode,
    input  logic [N_CH-1:0]   en_mask,
    input  logic              start,
    output logic [W-1:0]      out,
    output logic [SEL_W-1:0]  out_ch,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIRECT = 2'd1,
        SCAN   = 2'd2
    } state_t;

    state_t state;
    state_t state_nx;

    // Operation parameters captured at start. In scan mode mask_l is
    // consumed one bit per load, so it always holds the channels still
    // to be emitted.
    logic [SEL_W-1:0] s_l;
    logic             mode_l;
    logic [N_CH-1:0]  mask_l;
    logic             dir_pend;

    logic             accept;
    logic             xfer;
    logic             free;
    logic             scan_any;
    logic             load;
    logic             last;
    logic [SEL_W-1:0] scan_idx;
    logic [SEL_W-1:0] ld_ch;
    logic [W-1:0]     ld_data;

    // A mask-less scan request would never produce a sample, so it is
    // dropped here rather than entering SCAN.
    assign accept   = (state == IDLE) & start
                    & (~mode | (|en_mask));
    assign xfer     = out_valid & out_ready;
    assign free     = ~out_valid | xfer;
    assign scan_any = |mask_l;

    // Lowest remaining enabled channel.
    always_comb begin
        scan_idx = '0;
        for (int k = N_CH - 1; k >= 0; k--) begin
            if (mask_l[k]) begin
                scan_idx = SEL_W'(k);
            end
        end
    end

    assign ld_ch = mode_l ? scan_idx : s_l;

    // Out-of-range selects fall through to zero data.
    always_comb begin
        ld_data = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (SEL_W'(k) == ld_ch) begin
                ld_data = i[k*W +: W];
            end
        end
    end

    // Load and completion qualifiers per state. The final transfer is
    // an accept with nothing left to load behind it.
    always_comb begin
        load = 1'b0;
        last = 1'b0;
        unique case (state)
            DIRECT: begin
                load = free & dir_pend;
                last = xfer & ~dir_pend;
            end
            SCAN: begin
                load = free & scan_any;
                last = xfer & ~scan_any;
            end
            default: begin
                load = 1'b0;
                last = 1'b0;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_nx = mode ? SCAN : DIRECT;
                end
            end
            DIRECT, SCAN: begin
                if (last) begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // FSM outputs.
    always_comb begin
        busy = (state != IDLE);
    end

    // Captured operation parameters and scan progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_l      <= '0;
            mode_l   <= 1'b0;
            mask_l   <= '0;
            dir_pend <= 1'b0;
        end else if (accept) begin
            s_l      <= s;
            mode_l   <= mode;
            mask_l   <= en_mask;
            dir_pend <= ~mode;
        end else if (load) begin
            if (mode_l) begin
                // Clear the lowest set bit: the channel just loaded.
                mask_l <= mask_l & (mask_l - N_CH'(1));
            end else begin
                dir_pend <= 1'b0;
            end
        end
    end

    // Output register. A load in the same cycle as an accept keeps
    // out_valid high, giving one sample per clock under full ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out       <= '0;
            out_ch    <= '0;
            out_valid <= 1'b0;
        end else if (load) begin
            out       <= ld_data;
            out_ch    <= ld_ch;
            out_valid <= 1'b1;
        end else if (xfer) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done <= 1'b0;
        end else begin
            done <= last;
        end
    end

endmodule

// File: tb/tb_conditional_mux_scan.sv
// tb_conditional_mux_scan: directed bench for conditional_mux_scan with a
// transfer scoreboard on the 8x4 instance and inline checks on a 5x2 one.
module tb_conditional_mux_scan;

    localparam int AN = 8;
    localparam int AW = 4;
    localparam int BN = 5;
    localparam int BW = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    logic [AN*AW-1:0] a_i;
    logic [2:0]       a_s;
    logic             a_mode;
    logic [AN-1:0]    a_mask;
    logic             a_start;
    logic             a_rdy;
    logic [AW-1:0]    a_out;
    logic [2:0]       a_och;
    logic             a_ov;
    logic             a_busy;
    logic             a_done;

    logic [BN*BW-1:0] b_i;
    logic [2:0]       b_s;
    logic             b_mode;
    logic [BN-1:0]    b_mask;
    logic             b_start;
    logic             b_rdy;
    logic [BW-1:0]    b_out;
    logic [2:0]       b_och;
    logic             b_ov;
    logic             b_busy;
    logic             b_done;

    typedef struct packed {
        logic [2:0] ch;
        logic [3:0] d;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    conditional_mux_scan #(.N_CH(AN), .W(AW)) u_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .i         (a_i),
        .s         (a_s),
        .mode      (a_mode),
        .en_mask   (a_mask),
        .start     (a_start),
        .out       (a_out),
        .out_ch    (a_och),
        .out_valid (a_ov),
        .out_ready (a_rdy),
        .busy      (a_busy),
        .done      (a_done)
    );

    conditional_mux_scan #(.N_CH(BN), .W(BW)) u_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .i         (b_i),
        .s         (b_s),
        .mode      (b_mode),
        .en_mask   (b_mask),
        .start     (b_start),
        .out       (b_out),
        .out_ch    (b_och),
        .out_valid (b_ov),
        .out_ready (b_rdy),
        .busy      (b_busy),
        .done      (b_done)
    );

    always #5 clk = ~clk;

    initial begin
        #50000;
        $display("FAIL watchdog: summary not reached");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_scan(input logic [AN-1:0] m);
        for (int k = 0; k < AN; k++) begin
            if (m[k]) begin
                exp_q.push_back('{ch: 3'(k), d: a_i[k*AW +: AW]});
            end
        end
    endtask

    task automatic wait_done(input string tag, input int max);
        int n;
        n = 0;
        while (a_done !== 1'b1 && n < max) begin
            tick();
            n++;
        end
        chk(tag, a_done, 1);
    endtask

    task automatic b_direct(input string tag, input logic [2:0] sel,
                            input logic [1:0] exp);
        b_s     = sel;
        b_mode  = 1'b0;
        b_start = 1'b1;
        tick();
        b_start = 1'b0;
        tick();
        chk({tag, "_ov"}, b_ov, 1);
        chk({tag, "_och"}, b_och, sel);
        chk({tag, "_out"}, b_out, exp);
        tick();
        chk({tag, "_done"}, b_done, 1);
    endtask

    // Scoreboard: every transfer pops the next expected sample.
    always @(negedge clk) begin
        if (a_ov && a_rdy) begin : sb
            exp_t e;
            n_checks++;
            if (exp_q.size() == 0) begin
                n_errors++;
                $error("FAIL sb_extra: observed ch %0d data %0h, expected no transfer",
                       a_och, a_out);
            end else begin
                e = exp_q.pop_front();
                assert (a_och === e.ch && a_out === e.d) else begin
                    n_errors++;
                    $error("FAIL sb_xfer: observed ch %0d data %0h, expected ch %0d data %0h",
                           a_och, a_out, e.ch, e.d);
                end
            end
        end
    end

    initial begin
        logic [7:0] pat;
        a_i = '0; a_s = '0; a_mode = 1'b0; a_mask = '0;
        a_start = 1'b0; a_rdy = 1'b1;
        b_i = '0; b_s = '0; b_mode = 1'b0; b_mask = '0;
        b_start = 1'b0; b_rdy = 1'b1;

        // Asynchronous reset before any clock edge
        #1 rst_n = 1'b0;
        #2;
        chk("rst_out", a_out, 0);
        chk("rst_och", a_och, 0);
        chk("rst_ov", a_ov, 0);
        chk("rst_busy", a_busy, 0);
        chk("rst_done", a_done, 0);
        tick();
        tick();
        rst_n = 1'b1;

        // Direct: channel k carries bit k of 1010_0110, select 5
        pat = 8'b1010_0110;
        for (int k = 0; k < AN; k++) begin
            a_i[k*AW +: AW] = {3'b000, pat[k]};
        end
        a_s = 3'd5; a_mode = 1'b0; a_start = 1'b1;
        exp_q.push_back('{ch: 3'd5, d: 4'd1});
        tick();
        a_start = 1'b0;
        chk("dir_busy", a_busy, 1);
        chk("dir_lat_ov", a_ov, 0);
        tick();
        chk("dir_ov", a_ov, 1);
        chk("dir_och", a_och, 5);
        chk("dir_out", a_out, 1);
        chk("dir_nodone", a_done, 0);
        tick();
        chk("dir_ov_fall", a_ov, 0);
        chk("dir_done", a_done, 1);
        chk("dir_idle", a_busy, 0);
        tick();
        chk("dir_done_pulse", a_done, 0);
        chk("dir_q", exp_q.size(), 0);

        // Scan 1001_0010 at full rate, with a start while busy
        a_i = 32'h8C3A_5E71;
        a_mask = 8'b1001_0010; a_mode = 1'b1; a_start = 1'b1;
        push_scan(a_mask);
        tick();
        a_start = 1'b0;
        chk("scan_busy", a_busy, 1);
        chk("scan_lat_ov", a_ov, 0);
        tick();
        chk("scan_och1", a_och, 1);
        chk("scan_out1", a_out, 4'h7);
        a_start = 1'b1; a_mode = 1'b0; a_s = 3'd2; a_mask = 8'hFF;
        tick();
        chk("scan_och4", a_och, 4);
        chk("scan_out4", a_out, 4'hA);
        tick();
        chk("scan_och7", a_och, 7);
        chk("scan_out7", a_out, 4'h8);
        a_start = 1'b0;
        tick();
        chk("scan_ov_fall", a_ov, 0);
        chk("scan_done", a_done, 1);
        chk("scan_idle", a_busy, 0);
        tick();
        chk("busy_start_ignored", a_busy, 0);
        chk("scan_q", exp_q.size(), 0);

        // Direct sample reflects i at load time, not at start
        a_i = 32'h1111_1111;
        a_s = 3'd3; a_mode = 1'b0; a_mask = '0; a_start = 1'b1;
        tick();
        a_start = 1'b0;
        a_i = 32'h0000_B000;
        exp_q.push_back('{ch: 3'd3, d: 4'hB});
        tick();
        chk("late_och", a_och, 3);
        chk("late_out", a_out, 4'hB);
        wait_done("late_done", 4);
        chk("late_q", exp_q.size(), 0);

        // Backpressure on channel 4 for three cycles
        a_i = 32'hD4C3_B2A1;
        a_mask = 8'b1001_0010; a_mode = 1'b1; a_start = 1'b1;
        push_scan(a_mask);
        tick();
        a_start = 1'b0;
        tick();
        chk("bp_och1", a_och, 1);
        tick();
        chk("bp_och4", a_och, 4);
        a_rdy = 1'b0;
        for (int n = 0; n < 3; n++) begin
            tick();
            a_i = 32'hFFFF_FFFF;
            chk("bp_hold_ov", a_ov, 1);
            chk("bp_hold_och", a_och, 4);
            chk("bp_hold_out", a_out, 4'h3);
        end
        a_i = 32'hD4C3_B2A1;
        a_rdy = 1'b1;
        tick();
        chk("bp_och7", a_och, 7);
        chk("bp_out7", a_out, 4'hD);
        tick();
        chk("bp_done", a_done, 1);
        chk("bp_q", exp_q.size(), 0);

        // Scan request with an empty mask is dropped
        a_mode = 1'b1; a_mask = '0; a_start = 1'b1;
        tick();
        a_start = 1'b0;
        chk("m0_busy", a_busy, 0);
        chk("m0_ov", a_ov, 0);
        tick();
        chk("m0_done", a_done, 0);
        chk("m0_busy2", a_busy, 0);

        // Start in the same cycle as done
        a_i = 32'h9876_5432;
        a_s = 3'd6; a_mode = 1'b0; a_start = 1'b1;
        exp_q.push_back('{ch: 3'd6, d: 4'h8});
        tick();
        a_start = 1'b0;
        tick();
        chk("sod_och6", a_och, 6);
        tick();
        chk("sod_done", a_done, 1);
        a_mode = 1'b1; a_mask = 8'b0100_0001; a_start = 1'b1;
        push_scan(a_mask);
        tick();
        a_start = 1'b0;
        chk("sod_busy", a_busy, 1);
        wait_done("sod_done2", 8);
        chk("sod_q", exp_q.size(), 0);

        // Reset in the middle of a scan, then a full scan
        a_i = 32'hA5F0_3C69;
        a_mask = 8'hFF; a_mode = 1'b1; a_start = 1'b1;
        push_scan(a_mask);
        tick();
        a_start = 1'b0;
        tick();
        chk("mid_och0", a_och, 0);
        tick();
        chk("mid_och1", a_och, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_out", a_out, 0);
        chk("mid_rst_och", a_och, 0);
        chk("mid_rst_ov", a_ov, 0);
        chk("mid_rst_busy", a_busy, 0);
        chk("mid_rst_done", a_done, 0);
        exp_q.delete();
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        a_i = 32'h0123_4567;
        a_mask = 8'hFF; a_mode = 1'b1; a_start = 1'b1;
        push_scan(a_mask);
        tick();
        a_start = 1'b0;
        chk("post_rst_busy", a_busy, 1);
        wait_done("post_rst_done", 20);
        chk("post_rst_q", exp_q.size(), 0);

        // Five-channel instance: out-of-range and edge selects
        b_i = {2'b11, 2'b10, 2'b01, 2'b00, 2'b11};
        b_direct("b_s6", 3'd6, 2'b00);
        b_direct("b_s3", 3'd3, 2'b10);
        b_direct("b_s0", 3'd0, 2'b11);
        b_direct("b_s4", 3'd4, 2'b11);
        b_direct("b_s5", 3'd5, 2'b00);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/conditional_mux_scan.md
CONDITIONAL_MUX_SCAN -- requirements
Module: conditional_mux_scan

Interface
REQ-001 The block SHALL have parameter N_CH, default 8, giving the number of input channels (legal range 2..64).
REQ-002 The block SHALL have parameter W, default 1, giving the bits per channel (legal range 1..32).
REQ-003 The block SHALL derive local parameter SEL_W = max(1, ceil(log2(N_CH))) internally; it SHALL NOT be overridable.
REQ-004 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-005 Port clk, input, 1, rising-edge clock for all state.
REQ-006 Port rst_n, input, 1, asynchronous active-low reset.
REQ-007 Port i, input, N_CH*W, channel k occupies bits [k*W+W-1 : k*W].
REQ-008 Port s, input, SEL_W, channel select for direct mode, sampled on start.
REQ-009 Port mode, input, 1, 0 = direct (single sample), 1 = scan (sweep enabled channels); sampled on start.
REQ-010 Port en_mask, input, N_CH, scan-mode channel enables, sampled on start.
REQ-011 Port start, input, 1, single-cycle request to begin an operation.
REQ-012 Port out, output, W, registered sample data.
REQ-013 Port out_ch, output, SEL_W, index of the channel in out.
REQ-014 Port out_valid, output, 1, out/out_ch hold a sample not yet accepted.
REQ-015 Port out_ready, input, 1, consumer accepts the sample when out_valid and out_ready are both 1 on a rising edge.
REQ-016 Port busy, output, 1, high from the cycle after an accepted start until the cycle after the final transfer.
REQ-017 Port done, output, 1, single-cycle pulse in the cycle after the final transfer of an operation.

Function
REQ-018 The FSM SHALL have states IDLE, DIRECT, SCAN; busy = (state != IDLE).
REQ-019 In IDLE, start=1 SHALL latch s/mode/en_mask and enter DIRECT (mode=0) or SCAN (mode=1) next cycle.
REQ-020 start in IDLE with mode=1 and en_mask all zero SHALL be ignored: stay IDLE, no done.
REQ-021 start while busy SHALL be ignored with no effect on the running operation.
REQ-022 The output register SHALL load when out_valid=0 or (out_valid & out_ready), i.e. a "free slot".
REQ-023 While out_valid=1 and out_ready=0, out, out_ch and out_valid SHALL hold stable.
REQ-024 In DIRECT, the block SHALL load channel s_latched into out on the first free slot (out_ch = s_latched, out_valid=1), sampling i in that cycle.
REQ-025 The DIRECT load SHALL therefore have minimum latency 2 clocks from start to out_valid.
REQ-026 After the DIRECT sample is accepted, the FSM SHALL return to IDLE and pulse done.
REQ-027 If s_latched >= N_CH, out SHALL be all zeros with out_ch = s_latched.
REQ-028 In SCAN, the block SHALL emit one sample per enabled channel in ascending index order, skipping disabled channels with zero idle cycles between loads.
REQ-029 Back-to-back SCAN transfers SHALL sustain 1 sample/clock when out_ready is held at 1.
REQ-030 After the highest enabled channel is accepted, the FSM SHALL return to IDLE with done pulsed; there is no wrap-around.
REQ-031 Each SCAN sample SHALL reflect i in the cycle it is loaded, not at start.
REQ-032 out_valid SHALL fall in the cycle after the final acceptance unless a new operation has loaded (not possible: start requires IDLE).
REQ-033 A start in the same cycle as done is asserted SHALL be accepted.

Reset
REQ-034 When rst_n=0, the block SHALL immediately and asynchronously clear state=IDLE, out=0, out_ch=0, out_valid=0, busy=0, done=0 and the latched s/mode/en_mask=0, including mid-operation.
REQ-035 After rst_n deassertion, the first start SHALL be honoured on the first rising edge.

Verification
REQ-036 Direct mode: N_CH=8, W=1, i=8'b1010_0110, s=5, mode=0, start, out_ready=1 -> out=1, out_ch=5, out_valid for 1 cycle, done next cycle.
REQ-037 Scan mode: N_CH=8, W=4, en_mask=8'b1001_0010, out_ready=1 -> out_ch sequence 1,4,7 on consecutive cycles, then done, busy low.
REQ-038 Backpressure: scan with out_ready=0 for 3 cycles on channel 4 -> out/out_ch stable, no channel skipped or duplicated.
REQ-039 Edge cases: mask=0 scan start -> no busy/done. Start while busy -> ignored. N_CH=5, s=6 -> out=0, out_ch=6.
REQ-040 Reset: rst_n low mid-scan after channel 1 -> all outputs 0 asynchronously, and a new scan completes fully from channel 0.
